maxpool_core: RTL and testbench
===============================

MAXPOOL_CORE -- requirements
Module: maxpool_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the signed two's-complement pixel width.
REQ-002 SHALL have parameter IMG_W, default 4, meaning the input image width in pixels; it must be even and >= 2.
REQ-003 SHALL have parameter IMG_H, default 4, meaning the input image height in pixels; it must be even and >= 2.
REQ-004 SHALL derive localparams IN_NUM=IMG_W*IMG_H, OUT_NUM=(IMG_W/2)*(IMG_H/2), IN_ADR_WIDTH=$clog2(IN_NUM) and OUT_ADR_WIDTH=$clog2(OUT_NUM).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  rising-edge clock.
 rst  in  1  synchronous active-high reset.
 start  in  1  begin pooling; sampled only in IDLE.
 done  out  1  one-cycle completion pulse.
 in_adr  out  IN_ADR_WIDTH  input-buffer read address.
 in_data  in  DATA_WIDTH  input-buffer read data, combinational from in_adr in the same cycle.
 out_adr  out  OUT_ADR_WIDTH  output-buffer write address.
 out_data  out  DATA_WIDTH  output-buffer write data.
 out_wr  out  1  output-buffer write strobe.
REQ-007 SHALL make a non-even or < 2 IMG_W or IMG_H an elaboration error.

Function
REQ-008 SHALL compute 2x2 stride-2 max pooling over a row-major image (pixel (r,c) at address r*IMG_W+c) into a row-major output (output (i,j) at address i*(IMG_W/2)+j).
REQ-009 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-010 SHALL make the IDLE->READ transition when start=1, and otherwise stay in IDLE.
REQ-011 SHALL spend exactly 4 cycles per window in READ, element e=0..3, at in_adr=(2i+(e>>1))*IMG_W+2j+(e&1).
REQ-012 SHALL make the READ->WRITE transition after e=3.
REQ-013 SHALL spend 1 cycle in WRITE, then go to READ for the next window, or to DONE after output OUT_NUM-1.
REQ-014 SHALL spend 1 cycle in DONE, then go to IDLE.
REQ-015 SHALL visit windows in output-address order: j fastest, then i.
REQ-016 SHALL hold a DATA_WIDTH accumulator: at e=0 load in_data; at e=1..3 load the signed max(acc, in_data).
REQ-017 SHALL make the max compare signed, with ties keeping acc.
REQ-018 SHALL drive out_wr=1 only in WRITE, with out_data=acc and out_adr=i*(IMG_W/2)+j.
REQ-019 SHALL drive out_wr=0 at all other times.
REQ-020 SHALL drive done=1 only in DONE.
REQ-021 SHALL give this latency: with start high in cycle 0, output k is written in cycle 5k+5, done=1 in cycle 5*OUT_NUM+1, and IDLE is reached in cycle 5*OUT_NUM+2.
REQ-022 SHALL ignore start in READ, WRITE and DONE, with no restart and no queuing.
REQ-023 SHALL drive in_adr=0 outside READ.
REQ-024 SHALL hold out_adr at its last value outside WRITE.
REQ-025 SHALL perform no arithmetic overflow: address arithmetic at IN_ADR_WIDTH/OUT_ADR_WIDTH is exact by construction, and the counters wrap to 0 on entering DONE.

Reset
REQ-026 SHALL on rst=1 at a clock edge, in any state including mid-window, set state IDLE, acc=0, all counters 0, done=0, out_wr=0, in_adr=0 and out_adr=0.
REQ-027 SHALL make the cycle after rst deasserts IDLE, with start accepted from that cycle.

Structure
REQ-028 SHALL place the state encodings (IDLE=0, READ=1, WRITE=2, DONE=3, width 2) in the shared package cnn_pkg, alongside the shared DATA_WIDTH default.
REQ-029 SHALL compute address bases incrementally (row base += 2*IMG_W per output row, column += 2) using no multipliers.
REQ-030 SHALL use one sub-module, pool_window_addr_gen, that holds i, j, e and the row base and emits in_adr, out_adr and a last-window flag.

Verification
REQ-031 SHALL cover this scenario: 4x4 image, pixel k = k (0..15), start at cycle 0 -> writes (adr,data) = (0,5)@5, (1,7)@10, (2,13)@15, (3,15)@20, and done pulse @21.
REQ-032 SHALL cover this scenario: pixel k = -(k+1) -> outputs -1, -3, -9, -11 at addresses 0..3.
REQ-033 SHALL cover this scenario: window 0 = {0x80000000, 0x7FFFFFFF, 0x00000000, 0xFFFFFFFF} -> out_data 0x7FFFFFFF at adr 0.
REQ-034 SHALL cover this scenario: start re-pulsed at cycles 3 and 21 -> single run, exactly 4 writes and 1 done; then start at cycle 22 (IDLE) -> second identical run, done @43.
REQ-035 SHALL cover this scenario: rst=1 at cycle 7 mid-window -> out_wr stays 0 and no done; after start at cycle 10 -> full correct run, done @31.
REQ-036 SHALL cover this scenario: IMG_W=2, IMG_H=2, pixels {3,9,-4,9} -> single write (0,9) @5 and done @6.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: pooling FSM encodings and default pixel width.
package cnn_pkg;

    localparam int unsigned CNN_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } pool_state_t;

endpackage

// File: rtl/pool_window_addr_gen.sv
// Window/element walker for 2x2 stride-2 pooling; builds addresses incrementally.
module pool_window_addr_gen #(
    parameter int unsigned IMG_W         = 4,
    parameter int unsigned IMG_H         = 4,
    parameter int unsigned IN_ADR_WIDTH  = 4,
    parameter int unsigned OUT_ADR_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     elem_step,
    input  logic                     win_step,
    input  logic                     read_active,
    output logic [IN_ADR_WIDTH-1:0]  in_adr,
    output logic [OUT_ADR_WIDTH-1:0] out_idx,
    output logic                     last_elem,
    output logic                     last_win
);

    localparam int unsigned CW = IN_ADR_WIDTH;
    localparam logic [CW-1:0] J_LAST   = CW'(IMG_W / 2 - 1);
    localparam logic [CW-1:0] I_LAST   = CW'(IMG_H / 2 - 1);
    localparam logic [CW-1:0] ROW_STEP = CW'(2 * IMG_W);
    localparam logic [CW-1:0] ROW_OFF  = CW'(IMG_W);

    logic [1:0]    e;
    logic [CW-1:0] i;
    logic [CW-1:0] j;
    logic [CW-1:0] row_base;
    logic [CW-1:0] col;

    // Element counter advances every READ cycle; window counters advance on WRITE
    always_ff @(posedge clk) begin
        if (rst) begin
            e        <= 2'd0;
            i        <= '0;
            j        <= '0;
            row_base <= '0;
            col      <= '0;
            out_idx  <= '0;
        end else begin
            if (elem_step) begin
                e <= e + 2'd1;
            end
            if (win_step) begin
                if (last_win) begin
                    i        <= '0;
                    j        <= '0;
                    row_base <= '0;
                    col      <= '0;
                    out_idx  <= '0;
                end else begin
                    out_idx <= out_idx + OUT_ADR_WIDTH'(1);
                    if (j == J_LAST) begin
                        j        <= '0;
                        col      <= '0;
                        i        <= i + CW'(1);
                        row_base <= row_base + ROW_STEP;
                    end else begin
                        j   <= j + CW'(1);
                        col <= col + CW'(2);
                    end
                end
            end
        end
    end

    always_comb begin
        last_elem = (e == 2'd3);
        last_win  = (i == I_LAST) && (j == J_LAST);
        in_adr    = '0;
        if (read_active) begin
            in_adr = row_base + col + (e[1] ? ROW_OFF : CW'(0)) + CW'(e[0]);
        end
    end

endmodule

// File: rtl/maxpool_core.sv
// 2x2 stride-2 signed max pooling engine reading an input buffer and writing an output buffer.
module maxpool_core
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int unsigned IMG_W      = 4,
    parameter int unsigned IMG_H      = 4,
    localparam int unsigned IN_NUM        = IMG_W * IMG_H,
    localparam int unsigned OUT_NUM       = (IMG_W / 2) * (IMG_H / 2),
    localparam int unsigned IN_ADR_WIDTH  = $clog2(IN_NUM),
    // a single-output image still needs one address bit on the port
    localparam int unsigned OUT_ADR_WIDTH = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     done,
    output logic [IN_ADR_WIDTH-1:0]  in_adr,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic [OUT_ADR_WIDTH-1:0] out_adr,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_wr
);

    if ((IMG_W % 2 != 0) || (IMG_W < 2) || (IMG_H % 2 != 0) || (IMG_H < 2)) begin : g_bad_dims
        $error("maxpool_core: IMG_W and IMG_H must be even and >= 2");
    end

    pool_state_t state;
    pool_state_t state_next;

    logic                     last_elem;
    logic                     last_win;
    logic [OUT_ADR_WIDTH-1:0] out_idx;
    logic [DATA_WIDTH-1:0]    acc;
    logic                     elem_first;
    logic                     take_new;

    pool_window_addr_gen #(
        .IMG_W         (IMG_W),
        .IMG_H         (IMG_H),
        .IN_ADR_WIDTH  (IN_ADR_WIDTH),
        .OUT_ADR_WIDTH (OUT_ADR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .elem_step   (state == READ),
        .win_step    (state == WRITE),
        .read_active (state == READ),
        .in_adr      (in_adr),
        .out_idx     (out_idx),
        .last_elem   (last_elem),
        .last_win    (last_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (last_elem) state_next = WRITE;
            WRITE:   state_next = last_win ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // First element loads; later elements replace only when strictly greater
    always_comb begin
        elem_first = (in_adr == u_addr_gen.row_base + u_addr_gen.col) && (u_addr_gen.e == 2'd0);
        take_new   = $signed(in_data) > $signed(acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            out_adr <= '0;
            out_wr  <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (state == READ) begin
                if (elem_first || take_new) begin
                    acc <= in_data;
                end
                if (last_elem) begin
                    out_adr <= out_idx;
                end
            end
            out_wr <= (state_next == WRITE);
            done   <= (state_next == DONE);
        end
    end

    assign out_data = acc;

endmodule

// File: tb/tb_maxpool_core.sv
// Directed bench for maxpool_core: 4x4 runs, restart/reset robustness, and a 2x2 instance.
module tb_maxpool_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start2;
    logic        done;
    logic        done2;
    logic [3:0]  in_adr;
    logic [1:0]  in_adr2;
    logic [31:0] in_data;
    logic [31:0] in_data2;
    logic [1:0]  out_adr;
    logic [0:0]  out_adr2;
    logic [31:0] out_data;
    logic [31:0] out_data2;
    logic        out_wr;
    logic        out_wr2;

    logic [31:0] mem  [16];
    logic [31:0] mem2 [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign in_data  = mem[in_adr];
    assign in_data2 = mem2[in_adr2];

    maxpool_core #(.DATA_WIDTH(32), .IMG_W(4), .IMG_H(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .done     (done),
        .in_adr   (in_adr),
        .in_data  (in_data),
        .out_adr  (out_adr),
        .out_data (out_data),
        .out_wr   (out_wr)
    );

    maxpool_core #(.DATA_WIDTH(32), .IMG_W(2), .IMG_H(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .done     (done2),
        .in_adr   (in_adr2),
        .in_data  (in_data2),
        .out_adr  (out_adr2),
        .out_data (out_data2),
        .out_wr   (out_wr2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one 4x4 job starting at local cycle 0; extra start pulses at pa/pb (-1 = none)
    task automatic run4(input logic [31:0] exp0, input logic [31:0] exp1,
                        input logic [31:0] exp2, input logic [31:0] exp3,
                        input int pa, input int pb);
        logic [31:0] expv [4];
        int nwr;
        int ndone;
        expv[0] = exp0; expv[1] = exp1; expv[2] = exp2; expv[3] = exp3;
        nwr   = 0;
        ndone = 0;
        for (int c = 0; c <= 21; c++) begin
            if (c == 0) begin
                check("idle_out_wr", 64'(out_wr), 64'd0);
                check("idle_in_adr", 64'(in_adr), 64'd0);
            end
            if (c == 1) check("first_in_adr", 64'(in_adr), 64'd0);
            if (c == 3) check("elem2_in_adr", 64'(in_adr), 64'd4);
            if (c == 4) check("elem3_in_adr", 64'(in_adr), 64'd5);
            if (c == 6) check("win1_in_adr", 64'(in_adr), 64'd2);
            if (out_wr) begin
                if (nwr < 4) begin
                    check("wr_cycle", 64'(c), 64'(5 * nwr + 5));
                    check("wr_adr", 64'(out_adr), 64'(nwr));
                    check("wr_data", 64'(out_data), 64'(expv[nwr]));
                end
                nwr++;
            end
            if (done) begin
                check("done_cycle", 64'(c), 64'd21);
                ndone++;
            end
            start = (c == 0) || (c == pa) || (c == pb);
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        check("wr_count", 64'(nwr), 64'd4);
        check("done_count", 64'(ndone), 64'd1);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = 32'(k);
        mem2[0] = 32'd3; mem2[1] = 32'd9; mem2[2] = -32'sd4; mem2[3] = 32'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_adr", 64'(out_adr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // ascending pixels
        run4(32'd5, 32'd7, 32'd13, 32'd15, -1, -1);

        // all-negative pixels
        for (int k = 0; k < 16; k++) mem[k] = -32'(k + 1);
        run4(32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF7, 32'hFFFF_FFF5, -1, -1);

        // signed extremes in window 0
        for (int k = 0; k < 16; k++) mem[k] = 32'd0;
        mem[0] = 32'h8000_0000; mem[1] = 32'h7FFF_FFFF; mem[4] = 32'h0000_0000; mem[5] = 32'hFFFF_FFFF;
        run4(32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, -1, -1);

        // start re-pulsed mid-run and in DONE, then immediate second run
        for (int k = 0; k < 16; k++) mem[k] = 32'(k);
        run4(32'd5, 32'd7, 32'd13, 32'd15, 3, 21);
        run4(32'd5, 32'd7, 32'd13, 32'd15, -1, -1);

        // reset mid-window at cycle 7, restart at cycle 10
        for (int c = 0; c <= 9; c++) begin
            if (c == 8) begin
                check("midrst_out_adr", 64'(out_adr), 64'd0);
                check("midrst_in_adr", 64'(in_adr), 64'd0);
                check("midrst_out_data", 64'(out_data), 64'd0);
            end
            if (c >= 8) begin
                check("midrst_out_wr", 64'(out_wr), 64'd0);
                check("midrst_done", 64'(done), 64'd0);
            end
            start = (c == 0);
            rst   = (c == 7);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        run4(32'd5, 32'd7, 32'd13, 32'd15, -1, -1);

        // 2x2 instance: single window
        begin
            int nwr2;
            int nd2;
            nwr2 = 0;
            nd2  = 0;
            for (int c = 0; c <= 7; c++) begin
                if (out_wr2) begin
                    check("w2_cycle", 64'(c), 64'd5);
                    check("w2_adr", 64'(out_adr2), 64'd0);
                    check("w2_data", 64'(out_data2), 64'd9);
                    nwr2++;
                end
                if (done2) begin
                    check("d2_cycle", 64'(c), 64'd6);
                    nd2++;
                end
                start2 = (c == 0);
                @(posedge clk);
                @(negedge clk);
            end
            start2 = 1'b0;
            check("w2_count", 64'(nwr2), 64'd1);
            check("d2_count", 64'(nd2), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
